jb_dfe_time_delay_mc: RTL and testbench

Parametrised multi-channel programmable sample-delay line for the DL/UL DFE datapaths. It aligns N_CHANNELS complex streams by delaying each channel by an independently programmed whole number of samples, from 0 to MAX_DELAY-1. It replaces the fixed per-direction time-delay stage, which could only be bypassed or not. It adds three things that stage lacked: per-channel runtime delay, frame-aligned glitch-free delay update, and output muting while history is insufficient.

---
 rtl/jb_dfe_time_delay_mc.sv | 150 +++++++++++++++
 tb/tb_jb_dfe_time_delay_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jb_dfe_time_delay_mc.sv
// Multi-channel programmable sample-delay line: per-channel circular buffers, shadowed delay update, output muting.
// Define JB_DFE_TD_FRAME_ALIGN_EN to apply pending delays only on frame-marker samples.
module jb_dfe_time_delay_mc #(
  parameter int N_CHANNELS = 4,
  parameter int PRECISION  = 16,
  parameter int MAX_DELAY  = 64,
  parameter int MUTE_LEN   = 8
) (
  input  logic                                   clk_4x,
  input  logic                                   reset_4x,
  input  logic                                   s_valid,
  input  logic [N_CHANNELS*2*PRECISION-1:0]      s_data,
  input  logic                                   frm_mrkr,
  input  logic [N_CHANNELS*$clog2(MAX_DELAY)-1:0] delay_cfg,
  input  logic                                   delay_load,
  output logic                                   m_valid,
  output logic [N_CHANNELS*2*PRECISION-1:0]      m_data,
  output logic [N_CHANNELS*$clog2(MAX_DELAY)-1:0] delay_active,
  output logic                                   cfg_pending,
  output logic [N_CHANNELS-1:0]                  mute
);
  localparam int AW = $clog2(MAX_DELAY);
  localparam int HW = AW + 1;
  localparam int SW = 2 * PRECISION;
  localparam int CW = (MUTE_LEN > 0) ? $clog2(MUTE_LEN + 1) : 1;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t                           state_q, state_d;
  logic [N_CHANNELS-1:0][AW-1:0]    shadow_q, shadow_d;
  logic [N_CHANNELS-1:0][AW-1:0]    delay_act_q, delay_act_d;
  logic [N_CHANNELS-1:0][CW-1:0]    mcnt_q, mcnt_d;
  logic [HW-1:0]                    hist_q, hist_d;
  logic [AW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic                             v1_q, v1_d;
  logic [N_CHANNELS-1:0][AW-1:0]    addr1_q, addr1_d;
  logic [N_CHANNELS-1:0]            mute1_q, mute1_d;
  logic                             m_valid_q, m_valid_d;
  logic [N_CHANNELS*SW-1:0]         m_data_q, m_data_d;
  logic [N_CHANNELS-1:0]            mute_q, mute_d;

  logic                             apply;
  logic [N_CHANNELS-1:0][AW-1:0]    d_eff;
  logic [N_CHANNELS-1:0][CW-1:0]    m_eff;
  logic [N_CHANNELS-1:0]            chg;

  logic [SW-1:0] mem_q [N_CHANNELS][MAX_DELAY];

`ifdef JB_DFE_TD_FRAME_ALIGN_EN
  assign apply = (state_q == ARMED) && s_valid && frm_mrkr;
`else
  logic unused_frm_mrkr;
  assign unused_frm_mrkr = frm_mrkr;
  assign apply = (state_q == ARMED) && s_valid;
`endif

  // Update FSM and shadow register; a load coinciding with apply still re-arms
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    if (delay_load) begin
      shadow_d = delay_cfg;
      state_d  = ARMED;
    end else if (apply) begin
      state_d = IDLE;
    end
  end

  // Stage 0: pick the delay in force for this sample, form read address and mute decision
  always_comb begin
    delay_act_d = apply ? shadow_q : delay_act_q;
    wr_ptr_d    = s_valid ? wr_ptr_q + AW'(1) : wr_ptr_q;
    hist_d      = (s_valid && hist_q != HW'(MAX_DELAY)) ? hist_q + HW'(1) : hist_q;
    v1_d        = s_valid;
    d_eff       = '0;
    m_eff       = '0;
    chg         = '0;
    addr1_d     = '0;
    mute1_d     = '0;
    mcnt_d      = mcnt_q;
    for (int c = 0; c < N_CHANNELS; c++) begin
      d_eff[c]   = apply ? shadow_q[c] : delay_act_q[c];
      chg[c]     = apply && (shadow_q[c] != delay_act_q[c]);
      m_eff[c]   = chg[c] ? CW'(MUTE_LEN) : mcnt_q[c];
      addr1_d[c] = wr_ptr_q - d_eff[c];
      mute1_d[c] = ({1'b0, d_eff[c]} > hist_q) || (m_eff[c] != '0);
      if (s_valid && m_eff[c] != '0) begin
        mcnt_d[c] = m_eff[c] - CW'(1);
      end
    end
  end

  // Stage 1: read the buffer one cycle after the write so delay 0 sees the current sample
  always_comb begin
    m_valid_d = v1_q;
    m_data_d  = m_data_q;
    mute_d    = mute_q;
    if (v1_q) begin
      mute_d = mute1_q;
      for (int c = 0; c < N_CHANNELS; c++) begin
        m_data_d[c*SW +: SW] = mute1_q[c] ? '0 : mem_q[c][addr1_q[c]];
      end
    end
  end

  always_ff @(posedge clk_4x) begin
    if (s_valid) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        mem_q[c][wr_ptr_q] <= s_data[c*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk_4x) begin
    if (reset_4x) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      delay_act_q <= '0;
      mcnt_q      <= '0;
      hist_q      <= '0;
      wr_ptr_q    <= '0;
      v1_q        <= 1'b0;
      addr1_q     <= '0;
      mute1_q     <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      mute_q      <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      delay_act_q <= delay_act_d;
      mcnt_q      <= mcnt_d;
      hist_q      <= hist_d;
      wr_ptr_q    <= wr_ptr_d;
      v1_q        <= v1_d;
      addr1_q     <= addr1_d;
      mute1_q     <= mute1_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      mute_q      <= mute_d;
    end
  end

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign delay_active = delay_act_q;
  assign cfg_pending  = (state_q == ARMED);
  assign mute         = mute_q;

endmodule

// File: tb/tb_jb_dfe_time_delay_mc.sv
// Scoreboard bench for jb_dfe_time_delay_mc; expected samples are queued at stimulus time and matched at m_valid.
module tb_jb_dfe_time_delay_mc;
  localparam int N  = 4;
  localparam int P  = 16;
  localparam int MD = 64;
  localparam int ML = 8;
  localparam int AW = 6;
  localparam int SW = 2 * P;

  logic              clk_4x = 1'b0;
  logic              reset_4x;
  logic              s_valid;
  logic [N*SW-1:0]   s_data;
  logic              frm_mrkr;
  logic [N*AW-1:0]   delay_cfg;
  logic              delay_load;
  logic              m_valid;
  logic [N*SW-1:0]   m_data;
  logic [N*AW-1:0]   delay_active;
  logic              cfg_pending;
  logic [N-1:0]      mute;

  always #5 clk_4x = ~clk_4x;

  jb_dfe_time_delay_mc #(.N_CHANNELS(N), .PRECISION(P), .MAX_DELAY(MD), .MUTE_LEN(ML)) dut (
    .clk_4x(clk_4x), .reset_4x(reset_4x), .s_valid(s_valid), .s_data(s_data),
    .frm_mrkr(frm_mrkr), .delay_cfg(delay_cfg), .delay_load(delay_load),
    .m_valid(m_valid), .m_data(m_data), .delay_active(delay_active),
    .cfg_pending(cfg_pending), .mute(mute)
  );

  typedef struct {
    int              cyc;
    logic [N*SW-1:0] dat;
    logic [N-1:0]    mu;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon_e;
  logic [N*SW-1:0] smp_q[$];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;

  // Reference model state
  int              m_hist;
  logic            armed;
  logic [AW-1:0]   m_shadow [N];
  logic [AW-1:0]   m_dact [N];
  int              m_cnt [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N*SW-1:0] ramp(input int n);
    logic [N*SW-1:0] v;
    for (int c = 0; c < N; c++) v[c*SW +: SW] = {16'(n), 16'(-n)};
    return v;
  endfunction

  function automatic logic [N*AW-1:0] cfg_all(input int d);
    logic [N*AW-1:0] v;
    for (int c = 0; c < N; c++) v[c*AW +: AW] = AW'(d);
    return v;
  endfunction

  function automatic logic [N*AW-1:0] dact_packed();
    logic [N*AW-1:0] v;
    for (int c = 0; c < N; c++) v[c*AW +: AW] = m_dact[c];
    return v;
  endfunction

  always @(posedge clk_4x) cyc++;

  always @(posedge clk_4x) begin
    #1;
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_m_valid", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", 64'(cyc), 64'(mon_e.cyc));
        for (int c = 0; c < N; c++)
          check($sformatf("m_data_ch%0d", c), 64'(m_data[c*SW +: SW]), 64'(mon_e.dat[c*SW +: SW]));
        check("mute", 64'(mute), 64'(mon_e.mu));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      check("missing_m_valid", 64'd0, 64'd1);
    end
  end

  task automatic model_reset();
    m_hist = 0;
    armed  = 1'b0;
    smp_q.delete();
    for (int c = 0; c < N; c++) begin
      m_shadow[c] = '0;
      m_dact[c]   = '0;
      m_cnt[c]    = 0;
    end
  endtask

  task automatic step(input logic sv, input logic frm, input logic ld,
                      input logic [N*AW-1:0] cfg, input logic [N*SW-1:0] dat);
    logic            apply;
    exp_t            e;
    logic [N*SW-1:0] old;
    int              d, me, n;
    s_valid = sv; frm_mrkr = frm; delay_load = ld; delay_cfg = cfg; s_data = dat;
`ifdef JB_DFE_TD_FRAME_ALIGN_EN
    apply = armed && sv && frm;
`else
    apply = armed && sv;
`endif
    n = smp_q.size();
    e.cyc = cyc + 2; e.dat = '0; e.mu = '0;
    if (sv) smp_q.push_back(dat);
    for (int c = 0; c < N; c++) begin
      d  = apply ? int'(m_shadow[c]) : int'(m_dact[c]);
      me = (apply && m_shadow[c] != m_dact[c]) ? ML : m_cnt[c];
      if (sv) begin
        e.mu[c] = (m_hist < d) || (me != 0);
        if (!e.mu[c]) begin
          old = smp_q[n - d];
          e.dat[c*SW +: SW] = old[c*SW +: SW];
        end
        m_cnt[c] = (me > 0) ? me - 1 : 0;
      end
    end
    if (sv) begin
      exp_q.push_back(e);
      if (m_hist < MD) m_hist++;
    end
    if (apply) for (int c = 0; c < N; c++) m_dact[c] = m_shadow[c];
    if (ld) begin
      for (int c = 0; c < N; c++) m_shadow[c] = cfg[c*AW +: AW];
      armed = 1'b1;
    end else if (apply) begin
      armed = 1'b0;
    end
    @(posedge clk_4x); #1;
    check("cfg_pending", 64'(cfg_pending), 64'(armed));
    check("delay_active", 64'(delay_active), 64'(dact_packed()));
  endtask

  task automatic do_reset();
    reset_4x = 1'b1; s_valid = 1'b0; delay_load = 1'b0; frm_mrkr = 1'b0;
    delay_cfg = '0; s_data = '0;
    #2;
    exp_q.delete();
    @(posedge clk_4x); #1;
    reset_4x = 1'b0;
    model_reset();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data[63:0]) | 64'(m_data[N*SW-1:64]), 64'd0);
    check("rst_delay_active", 64'(delay_active), 64'd0);
    check("rst_cfg_pending", 64'(cfg_pending), 64'd0);
    check("rst_mute", 64'(mute), 64'd0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [N*AW-1:0] mixed;
    logic            frm;
    mixed = {6'd63, 6'd5, 6'd1, 6'd0};
    do_reset();

    // Ramp with delays 0/1/5/63
    step(1'b0, 1'b0, 1'b1, mixed, '0);
    for (int n = 0; n < 200; n++) step(1'b1, n == 0, 1'b0, '0, ramp(n));
    idle(4);
    check("ramp_delay_active", 64'(delay_active), 64'(mixed));

    // Sparse strobes, delay 5
    do_reset();
    step(1'b0, 1'b0, 1'b1, cfg_all(5), '0);
    for (int i = 0; i < 160; i++) step((i % 4) == 0, i == 0, 1'b0, '0, ramp(i / 4));
    idle(4);

    // Load at sample 10; marker at 40 in the frame-aligned build, toggling otherwise
    do_reset();
    for (int n = 0; n < 60; n++) begin
`ifdef JB_DFE_TD_FRAME_ALIGN_EN
      frm = (n == 40);
`else
      frm = (n % 3) == 0;
`endif
      step(1'b1, frm, n == 10, cfg_all(4), ramp(n));
    end
    check("frame_delay_active", 64'(delay_active), 64'(cfg_all(4)));

    // Two loads before the apply: last one wins
    step(1'b0, 1'b0, 1'b1, cfg_all(3), '0);
    step(1'b0, 1'b0, 1'b1, cfg_all(7), '0);
    step(1'b1, 1'b1, 1'b0, '0, ramp(60));
    check("double_load_applied", 64'(delay_active), 64'(cfg_all(7)));
    for (int n = 61; n < 80; n++) step(1'b1, 1'b0, 1'b0, '0, ramp(n));

    // Load coinciding with apply
    step(1'b0, 1'b0, 1'b1, cfg_all(2), '0);
    step(1'b1, 1'b1, 1'b1, cfg_all(9), ramp(80));
    check("coincide_old_applied", 64'(delay_active), 64'(cfg_all(2)));
    check("coincide_still_armed", 64'(cfg_pending), 64'd1);
    step(1'b1, 1'b1, 1'b0, '0, ramp(81));
    check("coincide_new_applied", 64'(delay_active), 64'(cfg_all(9)));
    for (int n = 82; n < 100; n++) step(1'b1, 1'b0, 1'b0, '0, ramp(n));

    // Mid-stream reset at delay 10
    do_reset();
    step(1'b0, 1'b0, 1'b1, cfg_all(10), '0);
    for (int n = 0; n < 30; n++) step(1'b1, 1'b1, 1'b0, '0, ramp(n));
    do_reset();
    step(1'b0, 1'b0, 1'b1, cfg_all(10), '0);
    for (int n = 0; n < 30; n++) step(1'b1, 1'b1, 1'b0, '0, ramp(500 + n));
    idle(5);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
